ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_keyboard_rx.sv | 166 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver for the keyboard driver.
// It synchronizes the raw PS/2 pins and deserializes 11-bit frames
// (start, 8 data bits LSB-first, odd parity, stop). When FILTER_BREAK is
// set, it also drops F0/E0 prefixes and break codes.
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   ps2_clk        raw PS/2 clock pin (asynchronous)
//   ps2_data       raw PS/2 data pin (asynchronous)
//   Keyboard_Data  last accepted scan code, held until the next one
//   ready_pulse    one-cycle strobe when Keyboard_Data updates
//   frame_err      one-cycle strobe on parity/stop/timeout rejection
module ps2_keyboard_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          FILTER_BREAK   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] Keyboard_Data,
  output logic       ready_pulse,
  output logic       frame_err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Synchronizers, edge detector and registered edge/data strobe
  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;
  logic fall_q, data_q;

  logic [1:0]    state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          parity_bit, parity_bit_nxt;
  logic          brk, brk_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic [7:0]    kb_nxt;
  logic          ready_nxt, err_nxt;
  logic          frame_ok_c;

  // Pin synchronization; the falling edge is registered with the data sampled alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      fall_q  <= 1'b0;
      data_q  <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      fall_q  <= clk_s3 & ~clk_s2;
      data_q  <= data_s2;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shift         <= 8'h00;
      parity_bit    <= 1'b0;
      brk           <= 1'b0;
      tmo           <= '0;
      Keyboard_Data <= 8'h00;
      ready_pulse   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shift         <= shift_nxt;
      parity_bit    <= parity_bit_nxt;
      brk           <= brk_nxt;
      tmo           <= tmo_nxt;
      Keyboard_Data <= kb_nxt;
      ready_pulse   <= ready_nxt;
      frame_err     <= err_nxt;
    end
  end

  // Next-state, filtering and timeout logic
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    parity_bit_nxt = parity_bit;
    brk_nxt        = brk;
    tmo_nxt        = tmo;
    kb_nxt         = Keyboard_Data;
    ready_nxt      = 1'b0;
    err_nxt        = 1'b0;
    // Odd parity over data+parity, and a high stop bit
    frame_ok_c     = data_q & (^{shift, parity_bit});

    if (fall_q) begin
      // A clock edge always wins over an expiring timeout
      tmo_nxt = '0;
      case (state)
        IDLE: begin
          if (!data_q) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end
        end
        DATA: begin
          shift_nxt   = {data_q, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          parity_bit_nxt = data_q;
          state_nxt      = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!frame_ok_c) begin
            err_nxt = 1'b1;
          end else if (FILTER_BREAK) begin
            if (shift == BREAK_CODE) begin
              brk_nxt = 1'b1;
            end else if (shift == EXT_CODE) begin
              brk_nxt = brk;
            end else if (brk) begin
              // Byte following F0 is the released key: swallow it
              brk_nxt = 1'b0;
            end else begin
              kb_nxt    = shift;
              ready_nxt = 1'b1;
            end
          end else begin
            kb_nxt    = shift;
            ready_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state == IDLE) begin
      tmo_nxt = '0;
    end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      // Stalled partial frame: drop it
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd0;
      err_nxt     = 1'b1;
      tmo_nxt     = '0;
    end else begin
      tmo_nxt = tmo + TW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kb1, kb0;
  logic       rdy1, rdy0, err1, err0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = 0;

  // Observed events
  logic [7:0] got1[$];
  logic [7:0] got0[$];
  int         lat_q[$];
  int         err_cnt1 = 0, err_cnt0 = 0, wide = 0;
  logic       prev_r1 = 1'b0, prev_r0 = 1'b0, prev_e1 = 1'b0, prev_e0 = 1'b0;

  // Reference model state
  logic [7:0] exp1[$];
  logic [7:0] exp0[$];
  logic [7:0] exp_kb1 = 8'h00, exp_kb0 = 8'h00;
  int         exp_err = 0;
  bit         m_brk = 1'b0;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(200), .FILTER_BREAK(1'b1)) dut_f (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .Keyboard_Data(kb1), .ready_pulse(rdy1), .frame_err(err1)
  );

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(200), .FILTER_BREAK(1'b0)) dut_u (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .Keyboard_Data(kb0), .ready_pulse(rdy0), .frame_err(err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rdy1) begin got1.push_back(kb1); lat_q.push_back(cyc - last_fall_cyc); end
    if (rdy0) begin got0.push_back(kb0); lat_q.push_back(cyc - last_fall_cyc); end
    if (err1) begin err_cnt1 = err_cnt1 + 1; last_err_cyc = cyc; end
    if (err0) err_cnt0 = err_cnt0 + 1;
    if ((rdy1 && prev_r1) || (rdy0 && prev_r0) || (err1 && prev_e1) || (err0 && prev_e0))
      wide = wide + 1;
    prev_r1 = rdy1; prev_r0 = rdy0; prev_e1 = err1; prev_e0 = err0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-level behaviour: valid frames go to both receivers, the filtered one drops prefixes/breaks
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err = exp_err + 1;
    end else begin
      exp0.push_back(b);
      exp_kb0 = b;
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) begin end
      else if (m_brk) m_brk = 1'b0;
      else begin exp1.push_back(b); exp_kb1 = b; end
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      repeat (10) @(negedge clk);
      ps2_data = f[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    send_bits(make_frame(b, bad_par, stop), 0, 10);
    model_frame(b, !bad_par && stop);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic check_step(input string tag);
    chk({tag, "/pulses_f"}, 32'(got1.size()), 32'(exp1.size()));
    for (int i = 0; i < exp1.size(); i++)
      chk($sformatf("%s/code_f[%0d]", tag, i),
          (i < got1.size()) ? 32'(got1[i]) : 32'hxxxxxxxx, 32'(exp1[i]));
    chk({tag, "/pulses_u"}, 32'(got0.size()), 32'(exp0.size()));
    for (int i = 0; i < exp0.size(); i++)
      chk($sformatf("%s/code_u[%0d]", tag, i),
          (i < got0.size()) ? 32'(got0[i]) : 32'hxxxxxxxx, 32'(exp0[i]));
    for (int i = 0; i < lat_q.size(); i++)
      chk($sformatf("%s/latency[%0d]", tag, i), 32'(lat_q[i]), 32'd4);
    chk({tag, "/kb_f"}, 32'(kb1), 32'(exp_kb1));
    chk({tag, "/kb_u"}, 32'(kb0), 32'(exp_kb0));
    chk({tag, "/errs_f"}, 32'(err_cnt1), 32'(exp_err));
    chk({tag, "/errs_u"}, 32'(err_cnt0), 32'(exp_err));
    chk({tag, "/wide_pulse"}, 32'(wide), 32'd0);
    got1.delete(); got0.delete(); exp1.delete(); exp0.delete(); lat_q.delete();
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;
    bit          bp, st;
    int          r;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset/kb_f", 32'(kb1), 32'h00);
    chk("reset/kb_u", 32'(kb0), 32'h00);
    chk("reset/rdy", 32'({rdy1, rdy0}), 32'd0);
    chk("reset/err", 32'({err1, err0}), 32'd0);

    // 1: single make code
    send_frame(8'h1C, 1'b0, 1'b1);
    check_step("t1");

    // 2: make / break sequence
    send_frame(8'h16, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h16, 1'b0, 1'b1);
    check_step("t2");

    // 3: extended codes
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_step("t3a");
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_step("t3b");

    // 4: parity and stop errors, then recovery
    send_frame(8'h1C, 1'b1, 1'b1);
    check_step("t4par");
    send_frame(8'h1C, 1'b0, 1'b0);
    check_step("t4stop");
    send_frame(8'h1D, 1'b0, 1'b1);
    check_step("t4ok");

    // 5: stalled partial frame times out
    f = make_frame(8'h2C, 1'b0, 1'b1);
    send_bits(f, 0, 4);
    repeat (250) @(negedge clk);
    exp_err = exp_err + 1;
    chk("t5/timeout_delay", 32'(last_err_cyc - last_fall_cyc), 32'd204);
    check_step("t5tmo");
    send_frame(8'h2C, 1'b0, 1'b1);
    check_step("t5ok");

    // 6: reset mid-frame; trailing bits of 0xF0 are all ones and must be ignored
    f = make_frame(8'hF0, 1'b0, 1'b1);
    send_bits(f, 0, 4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_brk = 1'b0; exp_kb1 = 8'h00; exp_kb0 = 8'h00;
    chk("t6/kb_f", 32'(kb1), 32'h00);
    chk("t6/kb_u", 32'(kb0), 32'h00);
    chk("t6/rdy_err", 32'({rdy1, rdy0, err1, err0}), 32'd0);
    send_bits(f, 5, 10);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    check_step("t6drop");
    send_frame(8'h29, 1'b0, 1'b1);
    check_step("t6ok");

    // Randomized frames, biased towards prefixes and occasional corruption
    for (int n = 0; n < 24; n++) begin
      r  = int'($urandom_range(0, 7));
      b  = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 7) != 0);
      send_frame(b, bp, st);
      if ((n % 6) == 5) check_step($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
